muladd32_seq: RTL and testbench



---
 rtl/muladd32_seq.sv | 108 ++++++++++
 tb/tb_muladd32_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muladd32_seq.sv
// ============================================================================
// Module : muladd32_seq
// Brief  : Sequential unsigned multiply-add p = q*d + r, K multiplier bits/cycle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muladd32_seq #(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int STEPS = WIDTH / K;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_d;
  logic [WIDTH-1:0]     r_r;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_p;
  logic [CW-1:0]        r_cnt;

  logic [WIDTH+K-1:0]   w_prod;
  logic [WIDTH+K-1:0]   w_sum;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_fix;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_step   = (r_state == RUN) && (r_cnt != '0);
  assign w_fix    = (r_state == RUN) && (r_cnt == '0);

  // Upper half plus d*chunk needs WIDTH+K bits; the whole sum shifts down into {hi, lo}.
  assign w_prod    = {{K{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_q[K-1:0]};
  assign w_sum     = {{K{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_prod;
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:K]};
  assign w_result  = r_acc + {{WIDTH{1'b0}}, r_r};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)     w_state_nxt = RUN;
      RUN:     if (r_cnt == '0)  w_state_nxt = DONE;
      DONE:    if (out_ready)    w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_d   <= '0;
      r_r   <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_q   <= q;
        r_d   <= d;
        r_r   <= r;
        r_acc <= '0;
        r_cnt <= CW'(STEPS);
      end
      if (w_step) begin
        r_acc <= w_acc_nxt;
        r_q   <= r_q >> K;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_fix) begin
        r_p <= w_result;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign p         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_muladd32_seq.sv
// ============================================================================
// Module : tb_muladd32_seq
// Brief  : Scoreboard bench for muladd32_seq, K=1 and K=4 instances side by side
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muladd32_seq;

  logic        clk;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] qq   [2];
  logic [31:0] dd   [2];
  logic [31:0] rr   [2];
  logic [63:0] pp   [2];

  logic [63:0] sb0[$];
  logic [63:0] sb1[$];

  int n_tests = 0;
  int n_fail  = 0;

  muladd32_seq #(.WIDTH(32), .K(1)) u_dut_k1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .q(qq[0]), .d(dd[0]), .r(rr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p(pp[0])
  );

  muladd32_seq #(.WIDTH(32), .K(4)) u_dut_k4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .q(qq[1]), .d(dd[1]), .r(rr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p(pp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    return {32'b0, a} * {32'b0, b} + {32'b0, c};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
    int t = 0;
    while (!ir[i] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ir[i]) begin
      check("send_timeout", 64'd0, 64'd1);
      return;
    end
    iv[i] = 1'b1;
    qq[i] = a;
    dd[i] = b;
    rr[i] = c;
    @(posedge clk);
    if (i == 0) sb0.push_back(model(a, b, c));
    else        sb1.push_back(model(a, b, c));
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_out(input int i, input int maxc, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[i] && lat < maxc);
    if (!ov[i]) check("out_timeout", 64'd0, 64'd1);
  endtask

  // Output handshakes are observed mid-cycle and checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ov[0] && ordy[0]) begin
      if (sb0.size() == 0) check("k1_spurious_out", 64'd1, 64'd0);
      else                 check("k1_sb_p", pp[0], sb0.pop_front());
    end
    if (rst_n && ov[1] && ordy[1]) begin
      if (sb1.size() == 0) check("k4_spurious_out", 64'd1, 64'd0);
      else                 check("k4_sb_p", pp[1], sb1.pop_front());
    end
  end

  initial begin
    int lat;
    int seen;
    int t;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
      qq[i] = '0; dd[i] = '0; rr[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", 64'(ov[i]), 64'd0);
      check("rst_p", pp[i], 64'd0);
      check("rst_in_ready", 64'(ir[i]), 64'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic K=1 op with latency and in_ready timing
    send(0, 32'd3, 32'd7, 32'd5);
    check("k1_in_ready_fall", 64'(ir[0]), 64'd0);
    wait_out(0, 60, lat);
    check("k1_latency", 64'(lat), 64'd33);
    check("k1_p_26", pp[0], 64'd26);
    @(posedge clk); #1;
    check("k1_ov_drop", 64'(ov[0]), 64'd0);
    check("k1_in_ready_back", 64'(ir[0]), 64'd1);

    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(0, 60, lat);
    check("k1_max", pp[0], 64'hFFFF_FFFF_0000_0000);
    @(posedge clk); #1;

    send(0, 32'h5555_5555, 32'd3, 32'd1);
    wait_out(0, 60, lat);
    check("k1_roundtrip", pp[0], 64'h0000_0001_0000_0000);
    @(posedge clk); #1;

    // K=4, zero multiplicand
    send(1, 32'hDEAD_BEEF, 32'd0, 32'h0000_CAFE);
    wait_out(1, 30, lat);
    check("k4_latency", 64'(lat), 64'd9);
    check("k4_d0", pp[1], 64'h0000_0000_0000_CAFE);
    @(posedge clk); #1;

    // Backpressure with new operands offered during the stall
    ordy[0] = 1'b0;
    send(0, 32'h89AB_CDEF, 32'h1234_5678, 32'h0BAD_F00D);
    wait_out(0, 60, lat);
    check("bp_latency", 64'(lat), 64'd33);
    iv[0] = 1'b1; qq[0] = 32'h1; dd[0] = 32'h1; rr[0] = 32'h1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_ov_hold", 64'(ov[0]), 64'd1);
      check("bp_p_hold", pp[0], model(32'h89AB_CDEF, 32'h1234_5678, 32'h0BAD_F00D));
      check("bp_in_ready_low", 64'(ir[0]), 64'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_ov_drop", 64'(ov[0]), 64'd0);
    check("bp_in_ready", 64'(ir[0]), 64'd1);
    send(0, 32'hCAFE_BABE, 32'h0F0F_1234, 32'h7777_0001);
    wait_out(0, 60, lat);
    check("bp_next_p", pp[0], model(32'hCAFE_BABE, 32'h0F0F_1234, 32'h7777_0001));
    @(posedge clk); #1;

    // Reset during RUN aborts the operation
    send(0, 32'h1234, 32'h5678, 32'h0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb0.delete();
    check("midrst_ov", 64'(ov[0]), 64'd0);
    check("midrst_p", pp[0], 64'd0);
    check("midrst_in_ready", 64'(ir[0]), 64'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ov[0]) seen++;
    end
    check("midrst_no_out", 64'(seen), 64'd0);
    send(0, 32'd2, 32'd2, 32'd2);
    wait_out(0, 60, lat);
    check("midrst_next_lat", 64'(lat), 64'd33);
    check("midrst_next_p", pp[0], 64'd6);
    @(posedge clk); #1;

    // Random operands on both instances concurrently
    fork
      begin
        for (int n = 0; n < 1000; n++) send(0, $urandom, $urandom, $urandom);
      end
      begin
        for (int n = 0; n < 1000; n++) send(1, $urandom, $urandom, $urandom);
      end
    join
    t = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_k1", 64'(sb0.size()), 64'd0);
    check("drain_k4", 64'(sb1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
